// File: rtl/fir_io_pkg.sv
// Shared types and the round/saturate quantiser for the 2-parallel FIR output path.
// Sample widths and the Q-format shift live here so every consumer agrees on them.
package fir_io_pkg;

   localparam int IN_W  = 40;
   localparam int OUT_W = 16;
   localparam int SHIFT = 15;

   typedef logic signed [IN_W-1:0]  in_t;
   typedef in_t                     pair_t [2];
   typedef logic signed [OUT_W-1:0] sample_t;

   typedef struct packed {
      sample_t s;
      logic    sat;
   } rs_t;

   localparam sample_t OUT_MAX = sample_t'({1'b0, {(OUT_W-1){1'b1}}});
   localparam sample_t OUT_MIN = sample_t'({1'b1, {(OUT_W-1){1'b0}}});

   localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1) << (SHIFT-1);
   localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'(OUT_MAX);
   localparam logic signed [IN_W:0] R_MIN = (IN_W+1)'(OUT_MIN);

   // One extra bit of headroom so adding the rounding constant can never wrap.
   function automatic rs_t round_sat(input in_t x);
      logic signed [IN_W:0] r;
      rs_t                  res;
      r       = (IN_W+1)'(x) + HALF;
      r       = r >>> SHIFT;
      res.sat = 1'b1;
      if (r > R_MAX) begin
         res.s = OUT_MAX;
      end else if (r < R_MIN) begin
         res.s = OUT_MIN;
      end else begin
         res.s   = r[OUT_W-1:0];
         res.sat = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_pair_fifo.sv
// Synchronous FIFO of quantised sample pairs with an occupancy output.
// Overflow/underflow protection is the caller's job; pointers wrap on power-of-two depth.
module fir_pair_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   output logic [W-1:0]  rd_data_o,
   output logic [AW:0]   level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en_i && !rd_en_i)      level_d = level_q + 1'b1;
      else if (!wr_en_i && rd_en_i) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

endmodule

// File: rtl/fir_par2_output_serializer.sv
// Quantises FIR sample pairs to 16 bits, buffers them, and streams them out one per cycle.
// in_ready is a pure register so the consumer's out_ready never reaches the filter combinationally.
module fir_par2_output_serializer
   import fir_io_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int SATC_W = 16,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  pair_t             inp,
   output logic              out_valid,
   input  logic              out_ready,
   output sample_t           out_data,
   output logic [SATC_W-1:0] sat_count,
   output logic [LVL_W-1:0]  level
);

   logic                 stage_v_q, stage_v_d;
   logic [2*OUT_W-1:0]   stage_q, stage_d;
   logic [SATC_W-1:0]    sat_count_q, sat_count_d;
   logic                 in_ready_q, in_ready_d;
   logic                 phase_q, phase_d;
   sample_t              hold_q, hold_d;

   rs_t                  rs_lo, rs_hi;
   logic                 accept;
   logic [1:0]           n_sat;
   logic [SATC_W:0]      sat_sum;
   logic [2*OUT_W-1:0]   head;
   logic [LVL_W-1:0]     fifo_level, level_d;
   sample_t              sel;
   logic                 hs, pop;

   fir_pair_fifo #(
      .W     (2*OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (stage_v_q),
      .wr_data_i (stage_q),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .level_o   (fifo_level)
   );

   always_comb begin
      rs_lo       = round_sat(inp[0]);
      rs_hi       = round_sat(inp[1]);
      accept      = in_valid && in_ready_q;
      n_sat       = {1'b0, rs_lo.sat} + {1'b0, rs_hi.sat};
      sat_sum     = {1'b0, sat_count_q} + (SATC_W+1)'(n_sat);
      stage_v_d   = accept;
      stage_d     = stage_q;
      sat_count_d = sat_count_q;
      if (accept) begin
         stage_d     = {rs_hi.s, rs_lo.s};
         sat_count_d = sat_sum[SATC_W] ? '1 : sat_sum[SATC_W-1:0];
      end

      out_valid = (fifo_level != '0);
      sel       = phase_q ? sample_t'(head[2*OUT_W-1:OUT_W]) : sample_t'(head[OUT_W-1:0]);
      hs        = out_valid && out_ready;
      pop       = hs && phase_q;
      phase_d   = hs ? ~phase_q : phase_q;
      hold_d    = out_valid ? sel : hold_q;
      out_data  = out_valid ? sel : hold_q;

      // Look ahead to next-cycle occupancy so in_ready can be a flop.
      level_d    = fifo_level + LVL_W'(stage_v_q) - LVL_W'(pop);
      in_ready_d = ((LVL_W+1)'(level_d) + (LVL_W+1)'(stage_v_d)) < (LVL_W+1)'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_v_q   <= 1'b0;
         stage_q     <= '0;
         sat_count_q <= '0;
         in_ready_q  <= 1'b0;
         phase_q     <= 1'b0;
         hold_q      <= '0;
      end else begin
         stage_v_q   <= stage_v_d;
         stage_q     <= stage_d;
         sat_count_q <= sat_count_d;
         in_ready_q  <= in_ready_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign sat_count = sat_count_q;
   assign level     = fifo_level;

endmodule

// File: tb/tb_fir_par2_output_serializer.sv
// Scoreboard bench for the pair serializer: expected samples are queued on accept
// and compared in order as the serial stream hands them off.
module tb_fir_par2_output_serializer;
   import fir_io_pkg::*;

   localparam int DEPTH  = 4;
   localparam int SATC_W = 16;
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   pair_t             inp;
   logic              out_valid;
   logic              out_ready = 1'b0;
   sample_t           out_data;
   logic [SATC_W-1:0] sat_count;
   logic [LVL_W-1:0]  level;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint sb[$];
   longint sat_m    = 0;
   int     acc_cnt  = 0;
   bit     stall_prev = 1'b0;
   longint prev_data  = 0;

   fir_par2_output_serializer #(.DEPTH(DEPTH), .SATC_W(SATC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp       (inp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_count (sat_count),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint q_model(input longint x, output bit sat);
      longint r;
      r   = (x + 64'sd16384) >>> 15;
      sat = 1'b1;
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
      else                 sat = 1'b0;
      return r;
   endfunction

   always @(negedge clk) begin
      bit s0, s1;
      longint e0, e1, exp_v;
      if (rst_n) begin
         if (out_valid && stall_prev) check("stall_hold", longint'(out_data), prev_data);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               exp_v = sb.pop_front();
               check("sample", longint'(out_data), exp_v);
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = longint'(out_data);
         if (in_valid && in_ready) begin
            e0 = q_model(longint'(inp[0]), s0);
            e1 = q_model(longint'(inp[1]), s1);
            sb.push_back(e0);
            sb.push_back(e1);
            sat_m = sat_m + longint'(s0) + longint'(s1);
            if (sat_m > 65535) sat_m = 65535;
            acc_cnt++;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic set_pair(input longint a, input longint b);
      inp[0] = a[IN_W-1:0];
      inp[1] = b[IN_W-1:0];
   endtask

   task automatic send_pair(input longint a, input longint b);
      int n = 0;
      set_pair(a, b);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", longint'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || level != 0) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", sb.size(), 0);
   endtask

   initial begin
      longint big;
      longint a, b;
      int n_acc, cyc;
      bit acc;
      set_pair(0, 0);

      // Reset values while held low
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_level", longint'(level), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_rel", longint'(in_ready), 1);

      // Single pair, latency and values
      out_ready = 1'b1;
      send_pair(32768, -32768);
      check("lat_stage", longint'(out_valid), 0);
      @(posedge clk); #1;
      check("lat_valid", longint'(out_valid), 1);
      check("lat_lane0", longint'(out_data), 1);
      @(posedge clk); #1;
      check("lat_lane1", longint'(out_data), -1);
      drain();
      check("sat_zero", longint'(sat_count), 0);

      // Rounding at the half point
      send_pair(16384, 16383);
      send_pair(-16384, -16385);
      drain();

      // Saturation in both directions
      big = longint'(1) << 38;
      send_pair(big, -big);
      drain();
      check("sat_two", longint'(sat_count), 2);

      // Back-pressure fill
      out_ready = 1'b0;
      n_acc = 0;
      set_pair(1 << 15, 2 << 15);
      in_valid = 1'b1;
      repeat (12) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            set_pair(longint'(2*n_acc+1) << 15, longint'(2*n_acc+2) << 15);
         end
      end
      in_valid = 1'b0;
      check("fill_accepted", n_acc, DEPTH);
      check("fill_in_ready", longint'(in_ready), 0);
      check("fill_level", longint'(level), DEPTH);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("ir_before_pop", longint'(in_ready), 0);
      @(posedge clk); #1;
      check("ir_after_pop", longint'(in_ready), 1);
      check("level_after_pop", longint'(level), DEPTH-1);
      drain();

      // Random stalls with in_valid every cycle
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         a = longint'({$urandom, $urandom});
         b = longint'({$urandom, $urandom});
         if (i % 3 == 0) begin
            a = a >>> 22;
            b = b >>> 22;
         end
         set_pair(a, b);
         out_ready = ($urandom_range(0, 99) < 60);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      check("sat_model", longint'(sat_count), sat_m);

      // Reset with level 3 and phase 1
      out_ready = 1'b0;
      send_pair(11 << 15, 12 << 15);
      send_pair(13 << 15, 14 << 15);
      send_pair(15 << 15, 16 << 15);
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_level", longint'(level), 3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("pre_rst_lane1", longint'(out_data), 12);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", longint'(out_valid), 0);
      check("async_level", longint'(level), 0);
      sb.delete();
      sat_m = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_pair(5 << 15, 7 << 15);
      @(posedge clk); #1;
      check("post_rst_lane0", longint'(out_data), 5);
      drain();

      // Saturation counter sticks at its maximum
      acc_cnt = 0;
      cyc = 0;
      set_pair(big, -big);
      in_valid = 1'b1;
      while (acc_cnt < 32768 && cyc < 80000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      in_valid = 1'b0;
      check("sat_bulk_pairs", acc_cnt, 32768);
      drain();
      check("sat_stick", longint'(sat_count), 65535);
      check("sat_stick_model", longint'(sat_count), sat_m);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
